cacheline_adaptor: RTL and testbench

//  Converts between the cache's full-line interface (consumer/producer of data_array lines) and
//  the burst physical-memory port. A fill assembles BURST_LEN beats into one line; a writeback

---
 rtl/cacheline_adaptor_pkg.sv | 25 ++
 rtl/cacheline_adaptor_if.sv | 30 +++
 rtl/cacheline_adaptor.sv | 116 +++++++++++
 tb/tb_cacheline_adaptor.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_adaptor_pkg.sv
// Shared widths, types and the FSM state encoding for the cache-line <-> burst memory adaptor.
package cacheline_adaptor_pkg;

  localparam int S_OFFSET  = 5;
  localparam int S_LINE    = 8 * (2 ** S_OFFSET);
  localparam int S_BURST   = 64;
  localparam int BURST_LEN = S_LINE / S_BURST;
  localparam int CNT_W     = $clog2(BURST_LEN);

  typedef logic [S_LINE-1:0]  line_t;
  typedef logic [S_BURST-1:0] burst_t;
  typedef logic [CNT_W-1:0]   count_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } adaptor_state_t;

  function automatic logic [31:0] align_addr(input logic [31:0] addr);
    return {addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Bus bundle for the adaptor: cache-side line request/response plus the burst memory port.
interface cacheline_adaptor_if;
  import cacheline_adaptor_pkg::*;

  logic        read_i;
  logic        write_i;
  logic [31:0] address_i;
  line_t       line_i;
  line_t       line_o;
  logic        resp_o;
  logic        err_o;
  logic [31:0] address_o;
  logic        read_o;
  logic        write_o;
  burst_t      burst_o;
  burst_t      burst_i;
  logic        resp_i;

  // slave: the adaptor's own view; master: the cache + memory environment around it
  modport slave (
    input  read_i, write_i, address_i, line_i, burst_i, resp_i,
    output line_o, resp_o, err_o, address_o, read_o, write_o, burst_o
  );

  modport master (
    output read_i, write_i, address_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, err_o, address_o, read_o, write_o, burst_o
  );

endinterface

// File: rtl/cacheline_adaptor.sv
// Line fill / writeback adaptor between cache and burst memory.
// Define CACHELINE_ADAPTOR_TIMEOUT_EN to abort a stalled burst after TIMEOUT idle cycles.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  #(parameter int TIMEOUT = 255)
`endif
(
  input logic clk,
  input logic reset,
  cacheline_adaptor_if.slave bus
);

  adaptor_state_t state_reg, state_next;
  count_t         count_reg, count_next;
  line_t          line_reg, line_next;
  line_t          wb_line_reg;
  logic [31:0]    addr_reg;
  logic           read_out, write_out, resp_out, abort;
  logic           fill_en;
  logic           unused_addr_bits;

  assign unused_addr_bits = ^bus.address_i[S_OFFSET-1:0];

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_reg;
  logic              busy;

  assign busy = (state_reg == READ) || (state_reg == WRITE);

  always_ff @(posedge clk) begin
    if (reset || !busy || bus.resp_i) begin
      wait_reg <= '0;
    end else begin
      wait_reg <= wait_reg + WAIT_W'(1);
    end
  end

  assign abort = busy && (wait_reg == WAIT_W'(TIMEOUT));
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    read_out   = 1'b0;
    write_out  = 1'b0;
    resp_out   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.write_i) begin
          state_next = WRITE;
          count_next = '0;
        end else if (bus.read_i) begin
          state_next = READ;
          count_next = '0;
        end
      end
      READ, WRITE: begin
        read_out  = (state_reg == READ);
        write_out = (state_reg == WRITE);
        if (bus.resp_i) begin
          count_next = count_reg + count_t'(1);
          if (count_reg == count_t'(BURST_LEN - 1)) state_next = DONE;
        end
      end
      DONE: begin
        resp_out   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A stalled burst is dropped outright: no resp_o, back to IDLE.
    if (abort) begin
      read_out   = 1'b0;
      write_out  = 1'b0;
      state_next = IDLE;
    end
  end

  assign fill_en = (state_reg == READ) && bus.resp_i;

  for (genvar gi = 0; gi < BURST_LEN; gi++) begin : g_slot
    assign line_next[gi*S_BURST +: S_BURST] =
      (fill_en && count_reg == count_t'(gi)) ? bus.burst_i : line_reg[gi*S_BURST +: S_BURST];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      line_reg    <= '0;
      wb_line_reg <= '0;
      addr_reg    <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      line_reg  <= line_next;
      if (state_reg == IDLE && (bus.read_i || bus.write_i)) begin
        addr_reg <= align_addr(bus.address_i);
        if (bus.write_i) wb_line_reg <= bus.line_i;
      end
    end
  end

  assign bus.read_o    = read_out;
  assign bus.write_o   = write_out;
  assign bus.resp_o    = resp_out;
  assign bus.err_o     = abort;
  assign bus.address_o = addr_reg;
  assign bus.line_o    = line_reg;
  assign bus.burst_o   = (state_reg == WRITE) ? wb_line_reg[count_reg*S_BURST +: S_BURST] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: fills, writebacks, gaps, priority, reset abort, stall/timeout.
`timescale 1ns/1ps
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  typedef struct {
    logic [31:0] addr;
    line_t       line;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cacheline_adaptor_if bus();

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  cacheline_adaptor #(.TIMEOUT(8)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  cacheline_adaptor dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  int     total = 0;
  int     bad = 0;
  exp_t   exp_q[$];
  burst_t beat_q[$];
  line_t  last_fill = '0;

  task automatic chk(input string tag, input logic [S_LINE-1:0] got, input logic [S_LINE-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Response monitor: every resp_o must match the oldest outstanding request.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.read_o || bus.write_o)
      chk("rw_excl", S_LINE'(bus.read_o & bus.write_o), S_LINE'(0));
    if (bus.resp_o) begin
      chk("resp_expected", S_LINE'(exp_q.size() != 0), S_LINE'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("resp_addr", S_LINE'(bus.address_o), S_LINE'(e.addr));
        chk("resp_line", bus.line_o, e.line);
        $display("txn resp addr=%08h line=%064h", bus.address_o, bus.line_o);
      end
    end
  end

  task automatic do_fill(input logic [31:0] addr, input line_t line, input logic [15:0] pat,
                         input int plen, input int stall);
    exp_t e;
    int   n;
    int   k;
    e.addr = addr & 32'hFFFF_FFE0;
    e.line = line;
    exp_q.push_back(e);
    last_fill = line;
    bus.read_i    = 1'b1;
    bus.address_i = addr;
    n = 0;
    while (!bus.read_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fill_start", S_LINE'(bus.read_o), S_LINE'(1));
    repeat (stall) @(negedge clk);
    if (stall > 0) begin
      chk("stall_read_hold", S_LINE'(bus.read_o), S_LINE'(1));
      chk("stall_no_err", S_LINE'(bus.err_o), S_LINE'(0));
    end
    k = 0;
    for (int i = 0; i < plen; i++) begin
      bus.resp_i = pat[i];
      if (pat[i]) begin
        bus.burst_i = line[k*S_BURST +: S_BURST];
        k++;
      end else begin
        bus.burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
      end
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    chk("fill_resp", S_LINE'(bus.resp_o), S_LINE'(1));
    bus.read_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] addr, input line_t line, input bit both, input bit gap);
    exp_t e;
    int   n;
    int   beats;
    bit   gapped;
    e.addr = addr & 32'hFFFF_FFE0;
    e.line = last_fill;
    exp_q.push_back(e);
    for (int k = 0; k < BURST_LEN; k++) beat_q.push_back(line[k*S_BURST +: S_BURST]);
    bus.write_i   = 1'b1;
    bus.read_i    = both;
    bus.address_i = addr;
    bus.line_i    = line;
    n = 0;
    while (!bus.write_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wb_start", S_LINE'(bus.write_o), S_LINE'(1));
    bus.line_i = ~line;
    beats  = 0;
    gapped = 1'b0;
    for (int g = 0; g < 12 && beats < BURST_LEN; g++) begin
      if (gap && beats == 2 && !gapped) begin
        bus.resp_i = 1'b0;
        gapped = 1'b1;
      end else begin
        chk("wb_beat", S_LINE'(bus.burst_o), S_LINE'(beat_q.pop_front()));
        bus.resp_i = 1'b1;
        beats++;
      end
      if (both) chk("wb_no_read", S_LINE'(bus.read_o), S_LINE'(0));
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    chk("wb_resp", S_LINE'(bus.resp_o), S_LINE'(1));
    bus.write_i = 1'b0;
    bus.read_i  = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    line_t l1, l2, lw, lw2, rl;
    int    n;
    l1  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    l2  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
           64'h5A5A_A5A5_0F0F_F0F0, 64'h8000_0000_0000_0001};
    lw  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
           64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    lw2 = ~l2;
    bus.read_i = 1'b0; bus.write_i = 1'b0; bus.address_i = '0; bus.line_i = '0;
    bus.burst_i = '0; bus.resp_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_flags", S_LINE'({bus.read_o, bus.write_o, bus.resp_o, bus.err_o}), S_LINE'(0));
    chk("rst_addr", S_LINE'(bus.address_o), S_LINE'(0));
    chk("rst_line", bus.line_o, '0);
    chk("rst_burst", S_LINE'(bus.burst_o), S_LINE'(0));
    reset = 1'b0;
    @(negedge clk);

    do_fill(32'h0000_1234, l1, 16'h000F, 4, 0);
    do_write(32'h0000_8040, lw, 1'b0, 1'b0);
    do_fill(32'hFFFF_FFFF, l2, 16'h000F, 4, 0);
    do_fill(32'h0000_1234, l1, 16'h0059, 7, 0);
    do_write(32'h1234_567F, lw2, 1'b1, 1'b1);

    // Abort a fill with reset after two beats.
    bus.read_i = 1'b1;
    bus.address_i = 32'h0000_0040;
    n = 0;
    while (!bus.read_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 2; i++) begin
      bus.resp_i = 1'b1;
      bus.burst_i = l2[i*S_BURST +: S_BURST];
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    bus.read_i = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_flags", S_LINE'({bus.read_o, bus.write_o, bus.resp_o, bus.err_o}), S_LINE'(0));
    chk("abort_addr", S_LINE'(bus.address_o), S_LINE'(0));
    chk("abort_line", bus.line_o, '0);
    last_fill = '0;
    reset = 1'b0;
    @(negedge clk);
    do_fill(32'h0000_2000, lw, 16'h000F, 4, 0);

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    bus.read_i = 1'b1;
    bus.address_i = 32'h0000_3000;
    n = 0;
    while (!bus.read_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!bus.err_o && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", S_LINE'(n), S_LINE'(8));
    chk("to_err", S_LINE'(bus.err_o), S_LINE'(1));
    chk("to_read_low", S_LINE'(bus.read_o), S_LINE'(0));
    bus.read_i = 1'b0;
    @(negedge clk);
    chk("to_err_pulse", S_LINE'(bus.err_o), S_LINE'(0));
    chk("to_idle", S_LINE'(bus.read_o), S_LINE'(0));
    $display("txn timeout abort cycles=%0d", n);
`else
    do_fill(32'h0000_3000, l2, 16'h000F, 4, 20);
`endif

    for (int r = 0; r < 3; r++) begin
      rl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_fill($urandom, rl, 16'h000F, 4, 0);
      do_write($urandom, ~rl, 1'b0, r[0]);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", S_LINE'(exp_q.size()), S_LINE'(0));
    chk("beats_empty", S_LINE'(beat_q.size()), S_LINE'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
